// File: rtl/data_mem_dump_engine.sv
// ---------------------------------------------------------------------------
// data_mem_dump_engine
//
// Post-run readout of the core's Data Memory. After a start pulse the engine
// walks byte addresses 0, STRIDE, 2*STRIDE ... DEPTH_BYTES-STRIDE, reads each
// word through a synchronous one-cycle read port and streams (address, word)
// pairs to a downstream sink over a valid/ready handshake.
//
// Optional feature: define DUMP_SKIP_ZERO_EN to suppress words that read as
// zero. The default build (macro undefined) reports every address.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous reset, active-high
//   start      in   one-cycle dump request, honoured only when idle
//   busy       out  high from accepted start until the done cycle
//   done       out  one-cycle pulse after the last pair is accepted
//   mem_rd_en  out  read strobe to Data Memory
//   mem_addr   out  byte address to Data Memory (holds when not reading)
//   mem_rdata  in   read data, valid the cycle after mem_rd_en
//   out_valid  out  out_addr/out_data hold a pair
//   out_ready  in   sink accepts when out_valid && out_ready
//   out_addr   out  byte address of the reported word
//   out_data   out  word read at out_addr
// ---------------------------------------------------------------------------
module data_mem_dump_engine #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned STRIDE      = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    // One extra pointer bit so the end comparison can never be hidden by wrap.
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH_BYTES - STRIDE);
    localparam logic [ADDR_W:0] STEP     = (ADDR_W+1)'(STRIDE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_FIN
    } state_t;

    state_t              state_q;
    logic [ADDR_W:0]     ptr_q;
    logic [ADDR_W:0]     ptr_d;
    logic                is_last;
    logic                skip_word;
    logic                busy_q;
    logic                done_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                out_valid_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic [DATA_W-1:0]   out_data_q;

    assign ptr_d   = ptr_q + STEP;
    assign is_last = (ptr_q == LAST_PTR);

`ifdef DUMP_SKIP_ZERO_EN
    assign skip_word = (mem_rdata == '0);
`else
    assign skip_word = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_READ;
                        ptr_q      <= '0;
                        busy_q     <= 1'b1;
                        rd_en_q    <= 1'b1;
                        mem_addr_q <= '0;
                    end
                end
                S_READ: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (skip_word) begin
                        // Suppressed word: advance exactly as an accepted pair would.
                        if (is_last) begin
                            state_q <= S_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_READ;
                            ptr_q      <= ptr_d;
                            rd_en_q    <= 1'b1;
                            mem_addr_q <= ptr_d[ADDR_W-1:0];
                        end
                    end else begin
                        state_q     <= S_SEND;
                        out_valid_q <= 1'b1;
                        out_addr_q  <= ptr_q[ADDR_W-1:0];
                        out_data_q  <= mem_rdata;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (is_last) begin
                            state_q <= S_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_READ;
                            ptr_q      <= ptr_d;
                            rd_en_q    <= 1'b1;
                            mem_addr_q <= ptr_d[ADDR_W-1:0];
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_data_mem_dump_engine.sv
// ---------------------------------------------------------------------------
// tb_data_mem_dump_engine
//
// Directed bench for data_mem_dump_engine: ramp dump, program-result image,
// randomly stalled sink, ignored restarts, and reset mid-scan. The Data Memory
// is modelled as a 64-word synchronous-read RAM.
// ---------------------------------------------------------------------------
module tb_data_mem_dump_engine;

`ifdef DUMP_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
    // Ramp is offset by one so word 0 is still reported when zeros are skipped.
    localparam logic [31:0] OFS = 32'd1;
`else
    localparam bit SKIP = 1'b0;
    localparam logic [31:0] OFS = 32'd0;
`endif

    logic        CLK;
    logic        RST;
    logic        start;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_addr;
    logic [31:0] out_data;

    data_mem_dump_engine #(
        .ADDR_W      (8),
        .DATA_W      (32),
        .DEPTH_BYTES (256),
        .STRIDE      (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data)
    );

    logic [31:0] ram [64];

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    // monitor state
    logic [7:0]  got_a [$];
    logic [31:0] got_d [$];
    int unsigned cyc = 0;
    int unsigned done_cnt;
    int unsigned last_acc_cyc;
    int unsigned done_cyc;
    logic        done_busy;
    int unsigned stab_err;
    logic        prev_stall;
    logic [7:0]  prev_a;
    logic [31:0] prev_d;
    logic        rdy_rand;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // synchronous-read RAM: address sampled with rd_en, data updated after the edge
    initial begin
        logic       en;
        logic [7:0] a;
        mem_rdata = '0;
        forever begin
            @(negedge CLK);
            en = mem_rd_en;
            a  = mem_addr;
            @(posedge CLK);
            #1;
            if (en) mem_rdata = ram[a[7:2]];
        end
    end

    // sink ready driver
    initial begin
        out_ready = 1'b1;
        rdy_rand  = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // stream monitor, sampled on the falling edge
    initial begin
        prev_stall = 1'b0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (RST) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!out_valid || out_addr != prev_a || out_data != prev_d))
                    stab_err++;
                if (out_valid && out_ready) begin
                    got_a.push_back(out_addr);
                    got_d.push_back(out_data);
                    last_acc_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc  = cyc;
                    done_busy = busy;
                end
                prev_stall = out_valid && !out_ready;
                prev_a     = out_addr;
                prev_d     = out_data;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_mon();
        got_a.delete();
        got_d.delete();
        done_cnt  = 0;
        stab_err  = 0;
        done_busy = 1'b0;
        last_acc_cyc = 0;
        done_cyc  = 0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 64; i++) ram[i] = 32'(i) + OFS;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (done) ok = 1'b1;
        end
    endtask

    // expected stream derived from the RAM contents
    task automatic cmp_stream(input string tag);
        int n = 0;
        for (int i = 0; i < 64; i++) begin
            if (!SKIP || ram[i] != 0) begin
                if (n < got_a.size()) begin
                    chk($sformatf("%s_addr%0d", tag, n), 32'(got_a[n]), 32'(i * 4));
                    chk($sformatf("%s_data%0d", tag, n), got_d[n], ram[i]);
                end
                n++;
            end
        end
        chk({tag, "_count"}, got_a.size(), n);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_rd_en"},     32'(mem_rd_en), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_out_addr"},  32'(out_addr),  32'd0);
        chk({tag, "_out_data"},  out_data,       32'd0);
    endtask

    initial begin
        bit ok;
        RST   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 64; i++) ram[i] = '0;
        clr_mon();
        tick();
        tick();
        check_idle_outputs("rst");
        RST = 1'b0;
        tick();

        // 1: ramp, sink always ready, latency and done timing
        fill_ramp();
        clr_mon();
        rdy_rand = 1'b0;
        pulse_start();
        chk("t1_busy_after_start", 32'(busy),      32'd1);
        chk("t1_rd_en_read",       32'(mem_rd_en), 32'd1);
        chk("t1_mem_addr_first",   32'(mem_addr),  32'd0);
        chk("t1_valid_c0",         32'(out_valid), 32'd0);
        tick();
        chk("t1_valid_c1",         32'(out_valid), 32'd0);
        chk("t1_rd_en_wait",       32'(mem_rd_en), 32'd0);
        tick();
        chk("t1_valid_c2",         32'(out_valid), 32'd1);
        chk("t1_first_addr",       32'(out_addr),  32'd0);
        chk("t1_first_data",       out_data,       OFS);
        wait_done(2000, ok);
        chk("t1_done_seen", 32'(ok), 32'd1);
        tick(); tick(); tick();
        cmp_stream("t1");
        chk("t1_done_latency", done_cyc - last_acc_cyc, 32'd1);
        chk("t1_done_busy",    32'(done_busy), 32'd0);
        chk("t1_done_count",   done_cnt,       32'd1);
        chk("t1_busy_end",     32'(busy),      32'd0);

        // 2: program-result image
        for (int i = 0; i < 64; i++) ram[i] = '0;
        ram[8'hD0 >> 2] = 32'h15;
        ram[8'hD4 >> 2] = 32'h700;
        ram[8'hD8 >> 2] = 32'hFFFFF90E;
        ram[8'hEC >> 2] = 32'hABCD;
        clr_mon();
        pulse_start();
        wait_done(2000, ok);
        chk("t2_done_seen", 32'(ok), 32'd1);
        tick(); tick();
        cmp_stream("t2");
        chk("t2_done_count", done_cnt, 32'd1);
`ifdef DUMP_SKIP_ZERO_EN
        chk("t2_four_pairs", got_a.size(), 32'd4);
`endif

        // 3: ramp with randomly stalling sink
        fill_ramp();
        clr_mon();
        rdy_rand = 1'b1;
        pulse_start();
        wait_done(4000, ok);
        chk("t3_done_seen", 32'(ok), 32'd1);
        rdy_rand = 1'b0;
        tick(); tick();
        cmp_stream("t3");
        chk("t3_stall_stable", stab_err, 32'd0);
        chk("t3_done_count",   done_cnt, 32'd1);

        // 4: start re-pulsed mid-scan and in the done cycle
        clr_mon();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick();
            if (got_a.size() >= 10) ok = 1'b1;
        end
        chk("t4_reached_pair10", 32'(ok), 32'd1);
        pulse_start();
        wait_done(2000, ok);
        chk("t4_done_seen", 32'(ok), 32'd1);
        pulse_start();
        for (int i = 0; i < 12; i++) tick();
        cmp_stream("t4");
        chk("t4_done_count", done_cnt,       32'd1);
        chk("t4_busy_after", 32'(busy),      32'd0);
        chk("t4_rd_en_after", 32'(mem_rd_en), 32'd0);

        // 5: reset while presenting address 0x40
        clr_mon();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (out_valid && out_addr == 8'h40) ok = 1'b1;
            else tick();
        end
        chk("t5_reached_0x40", 32'(ok), 32'd1);
        RST = 1'b1;
        tick();
        check_idle_outputs("t5_rst");
        RST = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_no_done",     done_cnt,       32'd0);
        chk("t5_idle_valid",  32'(out_valid), 32'd0);
        chk("t5_idle_rd_en",  32'(mem_rd_en), 32'd0);
        clr_mon();
        pulse_start();
        chk("t5_restart_addr", 32'(mem_addr), 32'd0);
        tick();
        tick();
        chk("t5_restart_valid", 32'(out_valid), 32'd1);
        chk("t5_restart_out_addr", 32'(out_addr), 32'd0);
        wait_done(2000, ok);
        chk("t5_done_seen", 32'(ok), 32'd1);
        tick(); tick();
        cmp_stream("t5");
        chk("t5_done_count", done_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
